// File: rtl/tx_pkg.sv
// Shared types and constants for the MAC TX frame arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tx_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WAIT_ACK,
        ST_STREAM,
        ST_GAP
    } tx_state_t;

    localparam int ETH_MAX_STD_BYTES   = 1514;
    localparam int ETH_MAX_JUMBO_BYTES = 9014;
    localparam int BYTE_CNT_W          = 14;

    // Index of a requester: 0 or 1.
    typedef logic req_idx_t;

    function automatic req_idx_t onehot_to_idx(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a tie goes to the requester not served last.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter2
    import tx_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Shares one MAC TX byte interface between two frame requesters with IFG and length policing.
// Latency: request to mac_tx_dvld 1 cycle; data path combinational once granted.
// Backpressure: requester holds its first byte until the routed ack; waiting requester stalls.
module tx_frame_arbiter
    import tx_pkg::*;
#(
    parameter int EN_DELAY        = 100,
    parameter int IFG_CYCLES      = 12,
    parameter int MAX_STD_BYTES   = ETH_MAX_STD_BYTES,
    parameter int MAX_JUMBO_BYTES = ETH_MAX_JUMBO_BYTES,
    parameter int ACK_TIMEOUT     = 1024
) (
    input  logic       tx_clk,
    input  logic       reset,
    input  logic [7:0] req0_data,
    input  logic       req0_dvld,
    output logic       req0_ack,
    input  logic [7:0] req1_data,
    input  logic       req1_dvld,
    output logic       req1_ack,
    input  logic       cfg_jumbo_en,
    input  logic       cfg_no_gen_crc,
    output logic       conf_tx_en,
    output logic       conf_tx_jumbo_en,
    output logic       conf_tx_no_gen_crc,
    output logic [7:0] mac_tx_data,
    output logic       mac_tx_dvld,
    input  logic       mac_tx_ack,
    output logic [1:0] grant,
    output logic       frame_done,
    output logic       err_ack_timeout,
    output logic       err_oversize
);

    localparam int TW = 16;

    tx_state_t             state_q, state_nxt;
    logic [1:0]            grant_q, grant_nxt;
    req_idx_t              last_q, last_nxt;
    logic [TW-1:0]         tmr_q, tmr_nxt;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_nxt;
    logic                  trunc_q, trunc_nxt;
    logic                  tx_en_q, tx_en_nxt;
    logic                  jumbo_q, jumbo_nxt;
    logic                  no_crc_q, no_crc_nxt;
    logic                  frame_done_q, frame_done_nxt;
    logic                  err_ack_q, err_ack_nxt;
    logic                  err_ovs_q, err_ovs_nxt;

    logic [1:0]            arb_gnt;
    logic                  gnt_dvld;
    logic [7:0]            gnt_data;
    logic [BYTE_CNT_W-1:0] max_len;
    logic                  at_max;
    logic                  fwd_en;

    rr_arbiter2 u_rr (
        .req  ({req1_dvld, req0_dvld}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    assign gnt_dvld = (grant_q[0] & req0_dvld) | (grant_q[1] & req1_dvld);
    assign gnt_data = grant_q[1] ? req1_data : req0_data;
    assign max_len  = jumbo_q ? BYTE_CNT_W'(MAX_JUMBO_BYTES) : BYTE_CNT_W'(MAX_STD_BYTES);
    assign at_max   = (byte_cnt_q == max_len);

    // The byte presented when byte_cnt already equals the limit is the first one past it,
    // so it is blocked combinationally in the same cycle the oversize is detected.
    assign fwd_en = (state_q == ST_WAIT_ACK) ||
                    ((state_q == ST_STREAM) && !trunc_q && !at_max);

    assign mac_tx_dvld = gnt_dvld & fwd_en;
    assign mac_tx_data = mac_tx_dvld ? gnt_data : 8'h00;

    assign req0_ack = mac_tx_ack & grant_q[0] & (state_q == ST_WAIT_ACK);
    assign req1_ack = mac_tx_ack & grant_q[1] & (state_q == ST_WAIT_ACK);

    assign grant              = grant_q;
    assign conf_tx_en         = tx_en_q;
    assign conf_tx_jumbo_en   = jumbo_q;
    assign conf_tx_no_gen_crc = no_crc_q;
    assign frame_done         = frame_done_q;
    assign err_ack_timeout    = err_ack_q;
    assign err_oversize       = err_ovs_q;

    always_comb begin
        state_nxt      = state_q;
        grant_nxt      = grant_q;
        last_nxt       = last_q;
        tmr_nxt        = tmr_q;
        byte_cnt_nxt   = byte_cnt_q;
        trunc_nxt      = trunc_q;
        tx_en_nxt      = tx_en_q;
        jumbo_nxt      = jumbo_q;
        no_crc_nxt     = no_crc_q;
        frame_done_nxt = 1'b0;
        err_ack_nxt    = 1'b0;
        err_ovs_nxt    = 1'b0;

        case (state_q)
            ST_INIT: begin
                tmr_nxt = tmr_q + 1'b1;
                if (tmr_q == TW'(EN_DELAY - 1)) begin
                    tx_en_nxt = 1'b1;
                    tmr_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end

            ST_IDLE: begin
                jumbo_nxt  = cfg_jumbo_en;
                no_crc_nxt = cfg_no_gen_crc;
                if (|arb_gnt) begin
                    grant_nxt = arb_gnt;
                    tmr_nxt   = '0;
                    state_nxt = ST_WAIT_ACK;
                end
            end

            ST_WAIT_ACK: begin
                if (!gnt_dvld) begin
                    // Requester gave up before the MAC took the first byte.
                    grant_nxt = 2'b00;
                    tmr_nxt   = '0;
                    state_nxt = ST_GAP;
                end else if (mac_tx_ack) begin
                    byte_cnt_nxt = BYTE_CNT_W'(1);
                    trunc_nxt    = 1'b0;
                    state_nxt    = ST_STREAM;
                end else begin
                    if (tmr_q != '1) begin
                        tmr_nxt = tmr_q + 1'b1;
                    end
                    if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                        err_ack_nxt = 1'b1;
                    end
                end
            end

            ST_STREAM: begin
                if (gnt_dvld) begin
                    if (byte_cnt_q != '1) begin
                        byte_cnt_nxt = byte_cnt_q + 1'b1;
                    end
                    if (at_max && !trunc_q) begin
                        trunc_nxt   = 1'b1;
                        err_ovs_nxt = 1'b1;
                    end
                end else begin
                    frame_done_nxt = 1'b1;
                    last_nxt       = onehot_to_idx(grant_q);
                    grant_nxt      = 2'b00;
                    tmr_nxt        = '0;
                    state_nxt      = ST_GAP;
                end
            end

            ST_GAP: begin
                tmr_nxt = tmr_q + 1'b1;
                if (tmr_q == TW'(IFG_CYCLES - 1)) begin
                    tmr_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            grant_q      <= 2'b00;
            last_q       <= 1'b1;
            tmr_q        <= '0;
            byte_cnt_q   <= '0;
            trunc_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            jumbo_q      <= 1'b0;
            no_crc_q     <= 1'b0;
            frame_done_q <= 1'b0;
            err_ack_q    <= 1'b0;
            err_ovs_q    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            grant_q      <= grant_nxt;
            last_q       <= last_nxt;
            tmr_q        <= tmr_nxt;
            byte_cnt_q   <= byte_cnt_nxt;
            trunc_q      <= trunc_nxt;
            tx_en_q      <= tx_en_nxt;
            jumbo_q      <= jumbo_nxt;
            no_crc_q     <= no_crc_nxt;
            frame_done_q <= frame_done_nxt;
            err_ack_q    <= err_ack_nxt;
            err_ovs_q    <= err_ovs_nxt;
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Bench for tx_frame_arbiter: directed frames, a MAC model that captures accepted bytes,
// and a per-cycle compare of the MAC-side outputs against the forwarding rules.
module tb_tx_frame_arbiter;

    localparam int STD_MAX   = 1514;
    localparam int JUMBO_MAX = 9014;

    logic       tx_clk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_dvld = 1'b0, req1_dvld = 1'b0;
    logic       req0_ack, req1_ack;
    logic       cfg_jumbo_en = 1'b0, cfg_no_gen_crc = 1'b0;
    logic       conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc;
    logic [7:0] mac_tx_data;
    logic       mac_tx_dvld;
    logic       mac_tx_ack = 1'b0;
    logic [1:0] grant;
    logic       frame_done, err_ack_timeout, err_oversize;

    tx_frame_arbiter dut (
        .tx_clk             (tx_clk),
        .reset              (reset),
        .req0_data          (req0_data),
        .req0_dvld          (req0_dvld),
        .req0_ack           (req0_ack),
        .req1_data          (req1_data),
        .req1_dvld          (req1_dvld),
        .req1_ack           (req1_ack),
        .cfg_jumbo_en       (cfg_jumbo_en),
        .cfg_no_gen_crc     (cfg_no_gen_crc),
        .conf_tx_en         (conf_tx_en),
        .conf_tx_jumbo_en   (conf_tx_jumbo_en),
        .conf_tx_no_gen_crc (conf_tx_no_gen_crc),
        .mac_tx_data        (mac_tx_data),
        .mac_tx_dvld        (mac_tx_dvld),
        .mac_tx_ack         (mac_tx_ack),
        .grant              (grant),
        .frame_done         (frame_done),
        .err_ack_timeout    (err_ack_timeout),
        .err_oversize       (err_oversize)
    );

    initial forever #5 tx_clk = ~tx_clk;

    int cyc = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Requester-side state: index of the byte currently presented.
    int idx[2];
    int t_start[2];
    int t_drop[2];

    // MAC model state and observation logs.
    bit         m_in_frame = 1'b0;
    int         m_wait = 0;
    int         m_len = 0;
    int         ack_delay = 3;
    logic       ack_next = 1'b0;
    logic [7:0] obs_bytes[$];
    int         obs_len[$];
    int         gq[$], gcq[$], gfq[$], fdq[$], eaq[$];
    int         eo_n = 0;
    logic [1:0] prev_grant = 2'b00;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        obs_bytes.delete(); obs_len.delete();
        gq.delete(); gcq.delete(); gfq.delete(); fdq.delete(); eaq.delete();
        eo_n = 0;
    endtask

    task automatic set_req(input int r, input logic v, input logic [7:0] d);
        if (r == 0) begin req0_dvld = v; req0_data = d; end
        else        begin req1_dvld = v; req1_data = d; end
    endtask

    // Compare outputs against the forwarding rules, log events, then advance the MAC model.
    task automatic monitor_step();
        int         r;
        logic       gd;
        logic [7:0] gdat;
        int         mx;
        logic       exp_dvld;
        mx = cfg_jumbo_en ? JUMBO_MAX : STD_MAX;
        r = (grant == 2'b10) ? 1 : 0;
        gd   = (r == 1) ? req1_dvld : req0_dvld;
        gdat = (r == 1) ? req1_data : req0_data;
        chk("grant_legal", {31'd0, grant == 2'b11}, 0);
        exp_dvld = (grant != 2'b00) && gd && (idx[r] < mx);
        chk("mac_tx_dvld", {31'd0, mac_tx_dvld}, {31'd0, exp_dvld});
        if (mac_tx_dvld) chk("mac_tx_data", {24'd0, mac_tx_data}, {24'd0, gdat});
        chk("req0_ack", {31'd0, req0_ack}, {31'd0, mac_tx_ack && grant == 2'b01 && !m_in_frame});
        chk("req1_ack", {31'd0, req1_ack}, {31'd0, mac_tx_ack && grant == 2'b10 && !m_in_frame});

        if (grant != prev_grant) begin
            if (grant != 2'b00) begin gq.push_back(int'(grant)); gcq.push_back(cyc); end
            else gfq.push_back(cyc);
        end
        prev_grant = grant;
        if (frame_done) fdq.push_back(cyc);
        if (err_oversize) eo_n++;
        if (err_ack_timeout) eaq.push_back(cyc);

        if (reset) begin
            if (m_in_frame) obs_len.push_back(m_len);
            m_in_frame = 1'b0;
            m_wait = 0;
        end else if (!m_in_frame) begin
            if (mac_tx_dvld && mac_tx_ack) begin
                m_in_frame = 1'b1; m_len = 1; m_wait = 0;
                obs_bytes.push_back(mac_tx_data);
            end else if (mac_tx_dvld) m_wait++;
            else m_wait = 0;
        end else begin
            if (mac_tx_dvld) begin obs_bytes.push_back(mac_tx_data); m_len++; end
            else begin obs_len.push_back(m_len); m_in_frame = 1'b0; end
        end
        ack_next = !reset && !m_in_frame && mac_tx_dvld && !mac_tx_ack && (m_wait >= ack_delay);
    endtask

    task automatic drive_frame(input int r, input int len, input int base);
        int w;
        @(posedge tx_clk); #1;
        set_req(r, 1'b1, 8'(base)); idx[r] = 0; t_start[r] = cyc;
        w = 0;
        do begin
            @(negedge tx_clk); w++;
        end while (!((r == 0) ? req0_ack : req1_ack) && w < 5000);
        if (w >= 5000) chk("ack_wait_bound", 0, 1);
        for (int i = 1; i < len; i++) begin
            @(posedge tx_clk); #1;
            set_req(r, 1'b1, 8'(base + i)); idx[r] = i;
        end
        @(posedge tx_clk); #1;
        set_req(r, 1'b0, 8'h00); idx[r] = 0; t_drop[r] = cyc;
    endtask

    task automatic check_frame(input int k, input int len, input int base);
        int off, bad;
        chk($sformatf("frame%0d_len", k), (obs_len.size() > k) ? obs_len[k] : -1, len);
        off = 0;
        for (int j = 0; j < k && j < obs_len.size(); j++) off += obs_len[j];
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (off + i >= obs_bytes.size()) bad++;
            else if (obs_bytes[off + i] !== 8'(base + i)) bad++;
        end
        chk($sformatf("frame%0d_bad_bytes", k), bad, 0);
    endtask

    initial begin
        int rise, t0s, t0d, w;
        idx[0] = 0; idx[1] = 0;
        fork
            forever begin @(negedge tx_clk); if (chk_en) monitor_step(); end
            forever begin @(posedge tx_clk); #1; mac_tx_ack = ack_next; end
        join_none

        // Reset values
        repeat (3) @(posedge tx_clk);
        #1 chk_en = 1'b1;
        @(negedge tx_clk);
        chk("reset_outputs", {22'd0, conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc, grant,
                              frame_done, err_ack_timeout, err_oversize, req0_ack, req1_ack},
            0);
        @(posedge tx_clk); #1 reset = 1'b0;

        // Start-up delay
        rise = -1;
        for (int k = 1; k <= 120; k++) begin
            @(posedge tx_clk); @(negedge tx_clk);
            chk("init_conf_tx_en", {31'd0, conf_tx_en}, {31'd0, k >= 100});
            chk("init_grant", {30'd0, grant}, 0);
            if (conf_tx_en && rise < 0) rise = k;
        end
        chk("conf_rise_cycle", rise, 100);

        // Single frame from req0, then req1 right behind it
        clear_logs();
        drive_frame(0, 60, 32);
        t0s = t_start[0]; t0d = t_drop[0];
        drive_frame(1, 5, 200);
        repeat (20) @(posedge tx_clk);
        @(negedge tx_clk);
        chk("t1_grant_cnt", gq.size(), 2);
        chk("t1_grant0_val", (gq.size() > 0) ? gq[0] : 0, 1);
        chk("t1_grant0_lat", (gcq.size() > 0) ? gcq[0] - t0s : -1, 1);
        chk("t1_grant0_fall", (gfq.size() > 0) ? gfq[0] - t0d : -1, 1);
        chk("t1_grant1_val", (gq.size() > 1) ? gq[1] : 0, 2);
        chk("t1_ifg_regrant", (gcq.size() > 1) ? gcq[1] - t0d : -1, 14);
        chk("t1_done_cnt", fdq.size(), 2);
        chk("t1_done_cycle", (fdq.size() > 0) ? fdq[0] - t0d : -1, 1);
        check_frame(0, 60, 32);
        check_frame(1, 5, 200);

        // Simultaneous requests, back to back
        clear_logs();
        fork
            begin drive_frame(0, 10, 16); drive_frame(0, 10, 112); end
            begin drive_frame(1, 10, 64); drive_frame(1, 10, 160); end
        join
        repeat (20) @(posedge tx_clk);
        @(negedge tx_clk);
        chk("t2_grant_cnt", gq.size(), 4);
        chk("t2_order0", (gq.size() > 0) ? gq[0] : 0, 1);
        chk("t2_order1", (gq.size() > 1) ? gq[1] : 0, 2);
        chk("t2_order2", (gq.size() > 2) ? gq[2] : 0, 1);
        chk("t2_order3", (gq.size() > 3) ? gq[3] : 0, 2);
        chk("t2_done_cnt", fdq.size(), 4);
        check_frame(0, 10, 16);
        check_frame(1, 10, 64);
        check_frame(2, 10, 112);
        check_frame(3, 10, 160);

        // Oversize with jumbo off; config change mid-frame is ignored
        clear_logs();
        #1 cfg_no_gen_crc = 1'b1;
        repeat (3) @(negedge tx_clk);
        chk("t3_conf_no_crc_idle", {31'd0, conf_tx_no_gen_crc}, 1);
        chk("t3_conf_jumbo", {31'd0, conf_tx_jumbo_en}, 0);
        fork
            drive_frame(1, 1600, 51);
            begin
                repeat (200) @(posedge tx_clk);
                #1 cfg_no_gen_crc = 1'b0;
                repeat (5) @(negedge tx_clk);
                chk("t3_cfg_mid_frame_hold", {31'd0, conf_tx_no_gen_crc}, 1);
            end
        join
        repeat (20) @(posedge tx_clk);
        @(negedge tx_clk);
        chk("t3_conf_no_crc_resampled", {31'd0, conf_tx_no_gen_crc}, 0);
        chk("t3_oversize_pulses", eo_n, 1);
        chk("t3_done_cnt", fdq.size(), 1);
        chk("t3_done_cycle", (fdq.size() > 0) ? fdq[0] - t_drop[1] : -1, 1);
        check_frame(0, STD_MAX, 51);

        // Ack withheld past the timeout
        clear_logs();
        ack_delay = 1100;
        drive_frame(0, 8, 77);
        repeat (20) @(posedge tx_clk);
        ack_delay = 3;
        @(negedge tx_clk);
        chk("t4_timeout_pulses", eaq.size(), 1);
        chk("t4_timeout_cycle", (eaq.size() > 0 && gcq.size() > 0) ? eaq[0] - gcq[0] : -1, 1024);
        chk("t4_done_cnt", fdq.size(), 1);
        check_frame(0, 8, 77);

        // Reset in the middle of a frame
        clear_logs();
        @(posedge tx_clk); #1;
        set_req(0, 1'b1, 8'd150); idx[0] = 0;
        w = 0;
        do begin @(negedge tx_clk); w++; end while (!req0_ack && w < 100);
        chk("t5_ack_wait", {31'd0, w < 100}, 1);
        for (int i = 1; i <= 20; i++) begin
            @(posedge tx_clk); #1;
            set_req(0, 1'b1, 8'(150 + i)); idx[0] = i;
        end
        reset = 1'b1;
        @(negedge tx_clk);
        chk("t5_pre_reset_dvld", {31'd0, mac_tx_dvld}, 1);
        @(posedge tx_clk); #1;
        set_req(0, 1'b0, 8'h00); idx[0] = 0;
        @(negedge tx_clk);
        chk("t5_dvld_after_reset", {31'd0, mac_tx_dvld}, 0);
        chk("t5_grant_after_reset", {30'd0, grant}, 0);
        chk("t5_conf_tx_en_after_reset", {31'd0, conf_tx_en}, 0);
        repeat (3) @(posedge tx_clk);
        #1 reset = 1'b0;
        repeat (30) @(negedge tx_clk);
        chk("t5_no_frame_done", fdq.size(), 0);
        chk("t5_conf_tx_en_init", {31'd0, conf_tx_en}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_frame_arbiter.md
Name: tx_frame_arbiter

Overview:
- Shares the single MAC TX byte interface (data / dvld / ack) between two frame-generating requesters, e.g. the ARP/probe frame sender and a reply/echo sender.
- Owns the MAC TX configuration pins and holds TX disabled for a start-up delay after reset.
- Per frame: round-robin grant, ack routing, inter-frame gap, length policing.
- Sits between the frame generators and the MAC wrapper on the tx_clk domain.

Parameters:
- EN_DELAY, 100, cycles after reset before conf_tx_en rises and arbitration starts.
- IFG_CYCLES, 12, idle cycles enforced after each frame before the next grant.
- MAX_STD_BYTES, 1514, maximum bytes forwarded per frame when jumbo is disabled (pre-CRC).
- MAX_JUMBO_BYTES, 9014, maximum bytes forwarded per frame when jumbo is enabled.
- ACK_TIMEOUT, 1024, WAIT_ACK cycles before err_ack_timeout pulses.

Ports:
- tx_clk  in  1  TX clock.
- reset  in  1  synchronous, active-high reset.
- req0_data  in  8  requester 0 byte.
- req0_dvld  in  1  requester 0 valid. Held high with the first byte until ack, then one byte per cycle, low after the last byte.
- req0_ack  out  1  MAC ack routed to requester 0.
- req1_data / req1_dvld / req1_ack  as req0, for requester 1.
- cfg_jumbo_en  in  1  jumbo request, sampled only in IDLE.
- cfg_no_gen_crc  in  1  CRC-suppress request, sampled only in IDLE.
- conf_tx_en  out  1  MAC TX enable.
- conf_tx_jumbo_en  out  1  registered copy of the sampled cfg_jumbo_en.
- conf_tx_no_gen_crc  out  1  registered copy of the sampled cfg_no_gen_crc.
- mac_tx_data  out  8  byte to MAC.
- mac_tx_dvld  out  1  valid to MAC.
- mac_tx_ack  in  1  MAC accepted the first byte.
- grant  out  2  one-hot current owner; 00 = none.
- frame_done  out  1  one-cycle pulse at the end of each frame.
- err_ack_timeout  out  1  one-cycle pulse.
- err_oversize  out  1  one-cycle pulse.

Behaviour:
- Reset values: all outputs 0, state INIT, last-served = requester 1 (so requester 0 wins the first tie), all counters 0.
- Clock and reset: one clock, tx_clk. Reset is synchronous and active-high. Reset mid-frame drops mac_tx_dvld and grant at the next edge. The partial frame is abandoned and no frame_done is issued.
- INIT: count to EN_DELAY, then set conf_tx_en=1 and go to IDLE. No grants are issued in INIT.
- IDLE:
  - Sample cfg_* into the conf_* registers.
  - If any reqN_dvld is high, register a grant and go to WAIT_ACK.
  - If both are high, grant the requester not served last.
  - Request-to-mac_tx_dvld latency is 1 cycle.
- Datapath: mac_tx_data / mac_tx_dvld are a combinational mux of the granted requester, gated by state (WAIT_ACK or STREAM) and the not-truncated flag. reqN_ack = mac_tx_ack & grant[N] & (state==WAIT_ACK). The non-granted ack is always 0.
- WAIT_ACK:
  - On mac_tx_ack, byte_cnt=1 and go to STREAM.
  - The wait counter pulses err_ack_timeout once on reaching ACK_TIMEOUT; the block keeps waiting.
  - If the granted dvld drops before ack (requester abort), go to GAP with no frame_done.
- STREAM:
  - Each cycle with granted dvld=1 increments byte_cnt (14 bits, saturating).
  - When byte_cnt equals the active max and dvld is still high the next cycle:
    - set truncated: mac_tx_dvld is forced 0 and the remaining bytes are discarded;
    - pulse err_oversize once.
  - When granted dvld falls: pulse frame_done, update last-served, go to GAP.
- GAP: hold grant=00 for IFG_CYCLES cycles, then go to IDLE. A request present at GAP exit is granted on the following cycle.
- Simultaneous events: mac_tx_ack while the other requester raises dvld has no effect; the other requester waits. Requests are level-sensitive, so nothing is lost.
- Config inputs that change mid-frame are ignored until the next IDLE.

Decomposition:
- Shared package tx_pkg:
  - state encoding (INIT, IDLE, WAIT_ACK, STREAM, GAP);
  - Ethernet size constants (1514, 9014);
  - the requester-index type.
- One natural sub-module: rr_arbiter2 (2-way round-robin grant from request and last-served bits).

Test Plan:
- Reset, hold 120 cycles -> conf_tx_en rises exactly at cycle 100; mac_tx_dvld=0 and grant=00 throughout.
- req0 sends a 60-byte frame, ack 3 cycles after dvld -> grant=01 one cycle after req0_dvld; the byte sequence on mac_tx_data matches the input; frame_done pulses once; no new grant for 12 cycles.
- req0 and req1 raise dvld in the same cycle, twice back-to-back -> grant order 01, 10, 01, 10; both acks never high together.
- Jumbo off, req1 streams 1600 bytes -> exactly 1514 bytes with dvld=1 at the MAC; err_oversize pulses once; frame_done when req1 drops dvld.
- Ack withheld 1100 cycles -> err_ack_timeout pulses once at cycle 1024; the frame proceeds normally after the late ack.
- Reset asserted at byte 20 of a frame -> dvld=0 and grant=00 next cycle; no frame_done; conf_tx_en returns to 0.
